// File: rtl/typedef_collection.sv
// Shared register width, memory bus encodings and loader state types for the
// memory unit and its loader.
`ifndef TYPEDEF_COLLECTION_SV
`define TYPEDEF_COLLECTION_SV

`define REGSIZE 8

package typedef_collection;

   // One word per address value.
   localparam int MEMORY_DEPTH = 2 ** `REGSIZE;

   typedef logic [`REGSIZE-1:0] DEFAULT_TYPE;

   // CPU bus command; the fourth code is unencoded and behaves like STAY.
   typedef enum logic [1:0] {
      MEMORY_STAY  = 2'b00,
      MEMORY_READ  = 2'b01,
      MEMORY_WRITE = 2'b10
   } MEMORY_FLAG_TYPE;

   typedef enum logic [1:0] {
      LOAD_IDLE = 2'b00,
      LOAD_RUN  = 2'b01,
      LOAD_DONE = 2'b10
   } LOADER_STATE_TYPE;

endpackage

`endif

// File: rtl/memory_loader.sv
// Boot loader: streams bytes into memory from address 0 while holding the CPU
// in reset, then releases the CPU once the image is complete.
module memory_loader
   import typedef_collection::*;
(
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                load_valid,
   input  logic [`REGSIZE-1:0] load_data,
   input  logic                load_last,
   output logic                load_ready,
   output logic                cpu_hold,
   output logic                mem_we,
   output logic [`REGSIZE-1:0] mem_addr,
   output logic [`REGSIZE-1:0] mem_data
);

   LOADER_STATE_TYPE    state_reg;
   logic [`REGSIZE-1:0] load_addr_reg;
   logic                load_ready_reg;
   logic                cpu_hold_reg;
   logic                accept;

   // A byte is taken whenever one is offered while the loader is still open.
   assign accept     = load_valid & load_ready_reg;
   assign mem_we     = accept;
   assign mem_addr   = load_addr_reg;
   assign mem_data   = load_data;
   assign load_ready = load_ready_reg;
   assign cpu_hold   = cpu_hold_reg;

   // Loader FSM; ready/hold are registered so they change together with the state.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_reg      <= LOAD_IDLE;
         load_addr_reg  <= '0;
         load_ready_reg <= 1'b1;
         cpu_hold_reg   <= 1'b1;
      end else begin
         case (state_reg)
            LOAD_IDLE: begin
               if (accept) begin
                  load_addr_reg <= `REGSIZE'(1);
                  if (load_last) begin
                     state_reg      <= LOAD_DONE;
                     load_ready_reg <= 1'b0;
                     cpu_hold_reg   <= 1'b0;
                  end else begin
                     state_reg <= LOAD_RUN;
                  end
               end
            end
            LOAD_RUN: begin
               if (accept) begin
                  // Address wraps to 0 after the top byte; the FSM stops there
                  // so mem[0] is never overwritten.
                  load_addr_reg <= load_addr_reg + `REGSIZE'(1);
                  if (load_last || (load_addr_reg == {`REGSIZE{1'b1}})) begin
                     state_reg      <= LOAD_DONE;
                     load_ready_reg <= 1'b0;
                     cpu_hold_reg   <= 1'b0;
                  end
               end
            end
            LOAD_DONE: begin
               state_reg      <= LOAD_DONE;
               load_ready_reg <= 1'b0;
               cpu_hold_reg   <= 1'b0;
            end
            default: begin
               state_reg      <= LOAD_IDLE;
               load_addr_reg  <= '0;
               load_ready_reg <= 1'b1;
               cpu_hold_reg   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/memory_unit.sv
// CPU-facing memory: combinational read port, synchronous write port.
// Optional boot loader compiled in with MEMORY_UNIT_LOADER_EN; without it the
// array is expected to be preloaded and load_* inputs are ignored.
module memory_unit #(
   parameter int MEMORY_DEPTH = typedef_collection::MEMORY_DEPTH
) (
   input  logic                                CLOCK,
   input  logic                                RESET,
   input  typedef_collection::MEMORY_FLAG_TYPE ctrl_bus,
   input  logic [`REGSIZE-1:0]                 addr_bus,
   input  logic [`REGSIZE-1:0]                 write_bus,
   output logic [`REGSIZE-1:0]                 read_bus,
   input  logic                                load_valid,
   input  logic [`REGSIZE-1:0]                 load_data,
   input  logic                                load_last,
   output logic                                load_ready,
   output logic                                cpu_hold
);

   logic [`REGSIZE-1:0] mem [0:MEMORY_DEPTH-1];

   logic                loader_we;
   logic [`REGSIZE-1:0] loader_addr;
   logic [`REGSIZE-1:0] loader_data;
   logic                cpu_read_en;
   logic                cpu_write_en;

`ifdef MEMORY_UNIT_LOADER_EN
   memory_loader u_loader (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .cpu_hold   (cpu_hold),
      .mem_we     (loader_we),
      .mem_addr   (loader_addr),
      .mem_data   (loader_data)
   );
`else
   // No loader: the CPU is never held and the load port is inert.
   logic unused_load;
   assign unused_load = ^{load_valid, load_data, load_last};
   assign loader_we   = 1'b0;
   assign loader_addr = '0;
   assign loader_data = '0;
   assign load_ready  = 1'b0;
   assign cpu_hold    = 1'b0;
`endif

   // CPU accesses are masked while the loader owns memory or during reset.
   assign cpu_read_en  = (ctrl_bus == typedef_collection::MEMORY_READ)  && !cpu_hold && !RESET;
   assign cpu_write_en = (ctrl_bus == typedef_collection::MEMORY_WRITE) && !cpu_hold && !RESET;

   // Same-cycle read data so the CPU can sample it before the next edge.
   always_comb begin
      read_bus = '0;
      if (cpu_read_en) begin
         read_bus = mem[addr_bus];
      end
   end

   // Single write port; CPU and loader are mutually exclusive through cpu_hold.
   always_ff @(posedge CLOCK) begin
      if (cpu_write_en) begin
         mem[addr_bus] <= write_bus;
      end else if (loader_we && !RESET) begin
         mem[loader_addr] <= loader_data;
      end
   end

endmodule

// File: tb/tb_memory_unit.sv
// Bench for memory_unit: directed scenarios plus random CPU traffic against a
// byte-array model of memory and a counting model of the loader.
module tb_memory_unit;
   import typedef_collection::*;

`ifdef MEMORY_UNIT_LOADER_EN
   localparam bit LOADER = 1'b1;
`else
   localparam bit LOADER = 1'b0;
`endif

   logic            CLOCK = 1'b0;
   logic            RESET;
   MEMORY_FLAG_TYPE ctrl_bus;
   logic [7:0]      addr_bus;
   logic [7:0]      write_bus;
   logic [7:0]      read_bus;
   logic            load_valid;
   logic [7:0]      load_data;
   logic            load_last;
   logic            load_ready;
   logic            cpu_hold;

   int checks = 0;
   int errors = 0;

   // Reference model: memory image, and loader progress (next position, finished flag).
   logic [7:0] ref_mem [256];
   int         ref_pos;
   bit         ref_done;

   memory_unit dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .ctrl_bus   (ctrl_bus),
      .addr_bus   (addr_bus),
      .write_bus  (write_bus),
      .read_bus   (read_bus),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .cpu_hold   (cpu_hold)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int a, input logic [7:0] v);
      ref_mem[a]  = v;
      dut.mem[a]  = v;
   endtask

   task automatic do_reset();
      RESET      = 1'b1;
      ctrl_bus   = MEMORY_READ;
      addr_bus   = 8'($urandom);
      load_valid = 1'b0;
      load_last  = 1'b0;
      tick();
      tick();
      check("reset_load_ready", {7'd0, load_ready}, {7'd0, LOADER});
      check("reset_cpu_hold", {7'd0, cpu_hold}, {7'd0, LOADER});
      check("reset_read_bus", read_bus, 8'h00);
      RESET    = 1'b0;
      ctrl_bus = MEMORY_STAY;
      ref_pos  = 0;
      ref_done = !LOADER;
   endtask

   task automatic cpu_read(input logic [7:0] a, output logic [7:0] obs);
      logic [7:0] exp;
      ctrl_bus = MEMORY_READ;
      addr_bus = a;
      #2;
      exp = ref_done ? ref_mem[a] : 8'h00;
      obs = read_bus;
      check($sformatf("read[%02h]", a), obs, exp);
      tick();
      ctrl_bus = MEMORY_STAY;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      ctrl_bus  = MEMORY_WRITE;
      addr_bus  = a;
      write_bus = d;
      tick();
      if (ref_done) ref_mem[a] = d;
      ctrl_bus = MEMORY_STAY;
   endtask

   task automatic cpu_idle(input MEMORY_FLAG_TYPE c, input logic [7:0] a, input logic [7:0] d, input string tag);
      ctrl_bus  = c;
      addr_bus  = a;
      write_bus = d;
      #2;
      check(tag, read_bus, 8'h00);
      tick();
      ctrl_bus = MEMORY_STAY;
   endtask

   task automatic load_byte(input logic [7:0] d, input bit last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      #2;
      check($sformatf("load_ready@%0d", ref_pos), {7'd0, load_ready}, {7'd0, !ref_done});
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      if (!ref_done) begin
         ref_mem[ref_pos] = d;
         ref_pos++;
         if (last || ref_pos == 256) ref_done = 1'b1;
      end
      check($sformatf("cpu_hold@%0d", ref_pos), {7'd0, cpu_hold}, {7'd0, !ref_done});
   endtask

   // Minimal accumulator CPU driving the bus: 01 MOV A,imm; 02 ADD A,imm; 03 MOV [imm],A; FF HLT.
   task automatic run_program();
      logic [7:0] pc;
      logic [7:0] acc;
      logic [7:0] op;
      logic [7:0] arg;
      bit         halted;
      pc = 8'h00; acc = 8'h00; halted = 1'b0;
      for (int n = 0; n < 16 && !halted; n++) begin
         cpu_read(pc, op);
         case (op)
            8'h01: begin cpu_read(pc + 8'd1, arg); acc = arg;       pc = pc + 8'd2; end
            8'h02: begin cpu_read(pc + 8'd1, arg); acc = acc + arg; pc = pc + 8'd2; end
            8'h03: begin cpu_read(pc + 8'd1, arg); cpu_write(arg, acc); pc = pc + 8'd2; end
            default: halted = 1'b1;
         endcase
      end
      check("cpu_halt_opcode", op, 8'hFF);
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] prog [7];
      RESET      = 1'b1;
      ctrl_bus   = MEMORY_STAY;
      addr_bus   = 8'h00;
      write_bus  = 8'h00;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      ref_done   = 1'b0;
      ref_pos    = 0;
      for (int i = 0; i < 256; i++) preload(i, 8'($urandom));

      // Basic three-byte image; CPU write and read attempts while held must be dropped.
      do_reset();
      v = ref_mem[8'h90] ^ 8'hFF;
      cpu_write(8'h90, v);
      load_byte(8'h03, 1'b0);
      cpu_read(8'h01, v);
      tick();
      load_byte(8'h05, 1'b0);
      load_byte(8'hF0, 1'b1);
      load_byte(8'h77, 1'b0);
      for (int i = 0; i < 4; i++) cpu_read(8'(i), v);
      cpu_read(8'h01, v);
      cpu_idle(MEMORY_STAY, 8'h01, 8'h00, "stay_read_bus");
      cpu_idle(MEMORY_FLAG_TYPE'(2'b11), 8'h02, 8'h55, "unencoded_read_bus");
      cpu_read(8'h02, v);
      cpu_read(8'h90, v);

      // Single write then neighbour untouched.
      cpu_write(8'h80, 8'hAA);
      cpu_read(8'h80, v);
      cpu_read(8'h81, v);

      // Random CPU traffic.
      for (int i = 0; i < 48; i++) begin
         logic [7:0] a;
         logic [7:0] d;
         a = 8'($urandom);
         d = 8'($urandom);
         case ($urandom_range(0, 3))
            0: cpu_idle(MEMORY_STAY, a, d, "rnd_stay");
            1: cpu_read(a, v);
            2: cpu_write(a, d);
            default: cpu_idle(MEMORY_FLAG_TYPE'(2'b11), a, d, "rnd_unencoded");
         endcase
      end
      for (int i = 0; i < 256; i += 17) cpu_read(8'(i), v);

      // Full 256-byte stream without last, then an extra byte that must be ignored.
      do_reset();
      for (int i = 0; i < 256; i++) load_byte(8'($urandom), 1'b0);
      load_byte(8'($urandom), 1'b0);
      for (int i = 0; i < 256; i++) cpu_read(8'(i), v);

      // Reset in the middle of a load restarts at address 0 and keeps older bytes.
      do_reset();
      load_byte(8'($urandom), 1'b0);
      load_byte(8'($urandom), 1'b0);
      do_reset();
      v = ref_mem[8'h10] ^ 8'h5A;
      cpu_write(8'h10, v);
      cpu_read(8'h10, v);
      load_byte(8'($urandom), 1'b0);
      load_byte(8'($urandom), 1'b1);
      for (int i = 0; i < 4; i++) cpu_read(8'(i), v);
      cpu_read(8'h10, v);

      // Program image: MOV A,07; ADD A,01; MOV [40],A; HLT.
      prog[0] = 8'h01; prog[1] = 8'h07; prog[2] = 8'h02; prog[3] = 8'h01;
      prog[4] = 8'h03; prog[5] = 8'h40; prog[6] = 8'hFF;
      do_reset();
`ifdef MEMORY_UNIT_LOADER_EN
      for (int i = 0; i < 7; i++) load_byte(prog[i], i == 6);
`else
      for (int i = 0; i < 7; i++) preload(i, prog[i]);
      for (int i = 0; i < 3; i++) load_byte(8'($urandom), 1'b1);
`endif
      run_program();
      cpu_read(8'h40, v);
      check("program_result", v, 8'h08);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 Parameter MEMORY_DEPTH, default 256, word count; address width equals `REGSIZE (8); SHALL equal 2**`REGSIZE.
REQ-002 CLOCK  input  1  sole clock; all state SHALL update on posedge CLOCK.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 ctrl_bus  input  MEMORY_FLAG_TYPE  MEMORY_READ / MEMORY_WRITE / MEMORY_STAY from the CPU.
REQ-005 addr_bus  input  `REGSIZE  CPU access address.
REQ-006 write_bus  input  `REGSIZE  CPU write data.
REQ-007 read_bus  output  `REGSIZE  read data to the CPU.
REQ-008 load_valid  input  1  loader byte offered.
REQ-009 load_data  input  `REGSIZE  loader byte.
REQ-010 load_last  input  1  marks final loader byte; qualified by load_valid.
REQ-011 load_ready  output  1  loader byte acceptable this cycle.
REQ-012 cpu_hold  output  1  when high, the CPU is held in reset (wired to the CPU RESET together with system RESET).

Function
REQ-013 Read path SHALL be combinational: read_bus = mem[addr_bus] when ctrl_bus==MEMORY_READ and cpu_hold==0; otherwise 8'h00, so the CPU samples data in the same cycle.
REQ-014 Write SHALL occur at posedge when ctrl_bus==MEMORY_WRITE and cpu_hold==0: mem[addr_bus] <= write_bus; the new value SHALL be visible on read_bus from the next cycle.
REQ-015 MEMORY_STAY or any unencoded ctrl_bus value SHALL neither modify memory nor drive read data.
REQ-016 Loader FSM states: LOAD_IDLE, LOAD_RUN, LOAD_DONE.
REQ-017 LOAD_IDLE: load_ready=1, cpu_hold=1; an accepted byte (load_valid & load_ready) SHALL be written to mem[0], set load_addr=1, and go to LOAD_RUN, or directly to LOAD_DONE if load_last=1.
REQ-018 LOAD_RUN: load_ready=1, cpu_hold=1; each accepted byte SHALL be written to mem[load_addr], and load_addr SHALL increment by 1.
REQ-019 LOAD_RUN -> LOAD_DONE on an accepted byte with load_last=1, or on the byte written at load_addr==8'hFF; load_addr SHALL wrap to 0 and SHALL NOT overwrite mem[0].
REQ-020 LOAD_DONE: load_ready=0, cpu_hold=0; load_valid SHALL be ignored; the state SHALL persist until RESET.
REQ-021 load_valid=0 in LOAD_IDLE or LOAD_RUN SHALL hold state and load_addr unchanged.
REQ-022 CPU bus activity SHALL be ignored while cpu_hold=1, so loader and CPU writes never collide.

Reset
REQ-023 On RESET: loader state=LOAD_IDLE, load_addr=0, load_ready=1, cpu_hold=1, read_bus=0.
REQ-024 Memory contents SHALL NOT be cleared by RESET; a reset mid-load SHALL return to LOAD_IDLE and restart from address 0, leaving prior contents intact.

Configuration
REQ-025 Macro MEMORY_UNIT_LOADER_EN, when defined, SHALL compile in the loader FSM, load_* behaviour and cpu_hold as specified above.
REQ-026 Without MEMORY_UNIT_LOADER_EN: load_ready=0, cpu_hold=0 at all times (including reset); load_* inputs SHALL be ignored; contents are preloaded by the bench through hierarchical access to the array.

Structure
REQ-027 LOADER_STATE_TYPE enum and the MEMORY_DEPTH constant SHALL live in typedef_collection.sv, beside MEMORY_FLAG_TYPE and DEFAULT_TYPE.
REQ-028 The loader FSM SHALL be the sub-module memory_loader (outputs: write enable, address, data, load_ready, cpu_hold); memory_unit SHALL hold the array and the CPU port logic.

Verification
REQ-029 Load bytes 8'h03,8'h05,8'hF0 (last on the third byte) -> mem[0..2]=03,05,F0; cpu_hold falls the cycle after the third acceptance; load_ready=0 afterwards.
REQ-030 After load, ctrl_bus=MEMORY_READ, addr_bus=8'h01 -> read_bus=8'h05 in the same cycle; ctrl_bus=MEMORY_STAY -> read_bus=8'h00.
REQ-031 ctrl_bus=MEMORY_WRITE, addr_bus=8'h80, write_bus=8'hAA for one cycle, then READ at 8'h80 -> read_bus=8'hAA; mem[8'h81] unchanged.
REQ-032 Stream 256 bytes with load_last never asserted -> LOAD_DONE after the byte at 8'hFF; mem[0] keeps the first byte; a 257th load_valid is ignored.
REQ-033 Assert RESET after 2 of 4 bytes -> LOAD_IDLE, load_addr=0, cpu_hold=1; the next byte is written to mem[0]; CPU WRITE during hold leaves memory unchanged.
REQ-034 Full system: program "MOV A,imm 8'h07; ADD A,imm 8'h01; MOV [imm 8'h40],A; HLT" loaded through the loader and run by the CPU -> mem[8'h40]=8'h08.
